// File: rtl/char_term_pkg.sv
// char_term_pkg: shared constants, types and helpers for the character
// terminal writer.
//   - Screen geometry (COLS, ROWS, CELLS) and the last legal row/col/cell.
//   - Control-code constants that the command decoder acts on.
//   - Register map selected by a[3:2].
//   - FSM state enum, command type enum and the packed FIFO entry.
//   - row_base(): row*80 built from shifts; byte_swap(): bus byte order.
package char_term_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] TAB   = 8'h09;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_ATTR   = 2'd1;
  localparam logic [1:0] REG_CURSOR = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_PUT,
    S_CLRLINE,
    S_CLRALL
  } state_t;

  typedef enum logic [1:0] {
    CHAR   = 2'd0,
    ATTR   = 2'd1,
    CURSOR = 2'd2
  } cmd_type_t;

  // CHAR/ATTR carry a byte in payload[7:0]; CURSOR carries {row[4:0], col[6:0]}.
  typedef struct packed {
    cmd_type_t   kind;
    logic [11:0] payload;
  } cmd_t;

  // row*80 = row*64 + row*16; keeps the index path free of a multiplier.
  function automatic logic [11:0] row_base(input logic [4:0] row);
    logic [11:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4);
  endfunction

  // The CPU bus presents bytes in reverse order relative to register fields.
  function automatic logic [31:0] byte_swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= SPACE) && (c != 8'h7F);
  endfunction

endpackage

// File: rtl/term_cmd_fifo.sv
// term_cmd_fifo: synchronous show-ahead FIFO for terminal commands.
//   clk, rst   : clock, synchronous active-low reset (flushes pointers)
//   push, din  : write request and data; accepted when not full, or when a
//                pop happens in the same cycle
//   pop        : consume the head entry (ignored when empty)
//   dout       : head entry, valid whenever empty is low
//   full, empty: occupancy flags
module term_cmd_fifo #(
  parameter int WIDTH      = 14,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]  mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic              wr_en, rd_en;

  // The extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign rd_en = pop && !empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; only pointers define validity, and
  // leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/char_term_writer.sv
// char_term_writer: MMIO text-terminal front end driving the character RAM.
//   clk, rst : clock, synchronous active-low reset
//   a, d, we : register window (a[3:2] selects DATA/ATTR/CURSOR/CTRL),
//              write data in bus byte order, write strobe
//   spo      : registered read data in bus byte order
//   vram_req, vram_gnt : write request / grant handshake
//   vram_a, vram_d, vram_we : cell address, {code, attr, 16'h0}, write enable
// Register writes become commands in a FIFO; a small FSM drains it, tracks
// the cursor and issues one cell write per granted cycle.
module char_term_writer
  import char_term_pkg::*;
#(
  parameter int         FIFO_DEPTH_LOG2 = 4,
  parameter logic [7:0] ATTR_RESET      = 8'h07
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        vram_req,
  input  logic        vram_gnt,
  output logic [31:0] vram_a,
  output logic [31:0] vram_d,
  output logic        vram_we
);

  logic [31:0]         w;
  logic [1:0]          reg_sel;
  logic                push, pop, status_rd;
  cmd_t                push_cmd, head, cmd_q;
  logic [$bits(cmd_t)-1:0] fifo_dout;
  logic                fifo_full, fifo_empty;
  logic                overflow, busy;
  state_t              state_q, state_d;
  logic [4:0]          row, row_nl;
  logic [6:0]          col, tab_col;
  logic [7:0]          attr, code, cell_code;
  logic [11:0]         clr_cnt, idx;
  logic                tab_wraps;
  logic [31:0]         rd_word;
  logic                unused_bits;

  assign w           = byte_swap(d);
  assign reg_sel     = a[3:2];
  assign unused_bits = ^{a[31:4], a[1:0], w[31:13]};

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    push             = 1'b0;
    push_cmd.kind    = CHAR;
    push_cmd.payload = '0;
    if (we) begin
      case (reg_sel)
        REG_DATA: begin
          push             = 1'b1;
          push_cmd.payload = {4'h0, w[7:0]};
        end
        REG_ATTR: begin
          push             = 1'b1;
          push_cmd.kind    = ATTR;
          push_cmd.payload = {4'h0, w[7:0]};
        end
        REG_CURSOR: begin
          push             = 1'b1;
          push_cmd.kind    = CURSOR;
          push_cmd.payload = {w[12:8], w[6:0]};
        end
        default: begin
          push             = w[0];
          push_cmd.payload = {4'h0, FF};
        end
      endcase
    end
  end

  term_cmd_fifo #(
    .WIDTH      ($bits(cmd_t)),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head      = cmd_t'(fifo_dout);
  assign pop       = (state_q == S_IDLE) && !fifo_empty;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  // There is no read strobe: a cycle addressing DATA with we low is a read.
  assign status_rd = !we && (reg_sel == REG_DATA);

  assign code      = cmd_q.payload[7:0];
  assign tab_col   = (col | 7'd7) + 7'd1;
  assign tab_wraps = (tab_col > LAST_COL);
  assign row_nl    = (row == LAST_ROW) ? '0 : row + 5'd1;

  // A drop in the same cycle as a status read wins, so the event is not lost.
  always_ff @(posedge clk) begin
    if (!rst)                              overflow <= 1'b0;
    else if (push && fifo_full && !pop)    overflow <= 1'b1;
    else if (status_rd)                    overflow <= 1'b0;
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_DATA:   rd_word = {28'd0, overflow, fifo_full, fifo_empty, busy};
      REG_CURSOR: rd_word = {19'd0, row, 1'b0, col};
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) spo <= '0;
    else      spo <= byte_swap(rd_word);
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_EXEC;
      S_EXEC: begin
        case (cmd_q.kind)
          CHAR: begin
            if (is_printable(code))                       state_d = S_PUT;
            else if (code == LF || (code == TAB && tab_wraps)) state_d = S_CLRLINE;
            else if (code == FF)                          state_d = S_CLRALL;
            else                                          state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_PUT:     if (vram_gnt) state_d = (col == LAST_COL) ? S_CLRLINE : S_IDLE;
      S_CLRLINE: if (vram_gnt && clr_cnt == 12'(LAST_COL)) state_d = S_IDLE;
      S_CLRALL:  if (vram_gnt && clr_cnt == LAST_CELL) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Cursor, attribute and clear counter. clr_cnt is always 0 outside the
  // clear states, so entering CLRLINE/CLRALL needs no explicit preload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_q   <= '0;
      row     <= '0;
      col     <= '0;
      attr    <= ATTR_RESET;
      clr_cnt <= '0;
    end else begin
      if (pop) cmd_q <= head;
      case (state_q)
        S_EXEC: begin
          case (cmd_q.kind)
            ATTR: attr <= cmd_q.payload[7:0];
            CURSOR: begin
              row <= (cmd_q.payload[11:7] > LAST_ROW) ? LAST_ROW : cmd_q.payload[11:7];
              col <= (cmd_q.payload[6:0] > LAST_COL) ? LAST_COL : cmd_q.payload[6:0];
            end
            CHAR: begin
              case (code)
                LF: begin
                  col <= '0;
                  row <= row_nl;
                end
                CR: col <= '0;
                BS: if (col != '0) col <= col - 7'd1;
                TAB: begin
                  if (tab_wraps) begin
                    col <= '0;
                    row <= row_nl;
                  end else begin
                    col <= tab_col;
                  end
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
        S_PUT: begin
          if (vram_gnt) begin
            if (col == LAST_COL) begin
              col <= '0;
              row <= row_nl;
            end else begin
              col <= col + 7'd1;
            end
          end
        end
        S_CLRLINE: begin
          if (vram_gnt) clr_cnt <= (clr_cnt == 12'(LAST_COL)) ? '0 : clr_cnt + 12'd1;
        end
        S_CLRALL: begin
          if (vram_gnt) begin
            if (clr_cnt == LAST_CELL) begin
              clr_cnt <= '0;
              row     <= '0;
              col     <= '0;
            end else begin
              clr_cnt <= clr_cnt + 12'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state, so address and data hold steady
  // while a request waits for its grant.
  always_comb begin
    vram_req  = 1'b0;
    idx       = '0;
    cell_code = SPACE;
    vram_a    = '0;
    vram_d    = '0;
    case (state_q)
      S_PUT: begin
        vram_req  = 1'b1;
        idx       = row_base(row) + {5'd0, col};
        cell_code = code;
      end
      S_CLRLINE: begin
        vram_req = 1'b1;
        idx      = row_base(row) + clr_cnt;
      end
      S_CLRALL: begin
        vram_req = 1'b1;
        idx      = clr_cnt;
      end
      default: ;
    endcase
    if (vram_req) begin
      vram_a = {8'h00, 2'b01, 8'h00, idx, 2'b00};
      vram_d = {cell_code, attr, 16'h0000};
    end
    vram_we = vram_req;
  end

endmodule
